// File: rtl/restoring_divider_4b.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake.
// Produces one quotient bit per clock; results are held until the next accepted start.
module restoring_divider_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   part_rem_q, part_rem_d;
    logic [WIDTH-1:0] part_quo_q, part_quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shift_rem;
    logic [WIDTH-1:0] shift_quo;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    // Two's-complement subtraction a - {0,b}; bit WIDTH of the result is the borrow.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0]   a,
                                                 input logic [WIDTH-1:0] b);
        return a + ~{1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
    endfunction

    always_comb begin
        shift_rem = {part_rem_q[WIDTH-1:0], part_quo_q[WIDTH-1]};
        shift_quo = {part_quo_q[WIDTH-2:0], 1'b0};
        trial     = trial_sub(shift_rem, dvs_q);
        if (trial[WIDTH] == 1'b0) begin
            step_rem = trial;
            step_quo = {shift_quo[WIDTH-1:1], 1'b1};
        end else begin
            step_rem = shift_rem;
            step_quo = shift_quo;
        end
    end

    always_comb begin
        state_d    = state_q;
        part_rem_d = part_rem_q;
        part_quo_d = part_quo_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    if (divisor != '0) begin
                        dvs_d      = divisor;
                        part_rem_d = '0;
                        part_quo_d = dividend;
                        cnt_d      = CNT_W'(WIDTH);
                        state_d    = CALC;
                    end else begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            CALC: begin
                part_rem_d = step_rem;
                part_quo_d = step_quo;
                cnt_d      = cnt_q - CNT_W'(1);
                // Results are published only on the final iteration.
                if (cnt_q == CNT_W'(1)) begin
                    quot_d  = step_quo;
                    rem_d   = step_rem[WIDTH-1:0];
                    dbz_d   = 1'b0;
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            part_rem_q <= '0;
            part_quo_q <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            part_rem_q <= part_rem_d;
            part_quo_q <= part_quo_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == FIN);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_4b.sv
// Self-checking bench for restoring_divider_4b: directed handshake scenarios,
// an exhaustive sweep and random operations against a plain-arithmetic model.
module tb_restoring_divider_4b;

    localparam int WIDTH = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int n_checks = 0;
    int n_errors = 0;
    int hold_q   = 0;
    int hold_r   = 0;

    restoring_divider_4b #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives a request at a falling edge; returns at the falling edge after acceptance.
    task automatic start_op(input int a, input int b);
        start    = 1'b1;
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        @(negedge clk);
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    // Waits (bounded) for done, checking latency, busy, held outputs and the result.
    task automatic await_result(input int a, input int b);
        int lat;
        int nbusy;
        int exp_q;
        int exp_r;
        int exp_z;
        int dq;
        int dr;
        lat   = 1;
        nbusy = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) nbusy++;
            check_eq("hold_quotient", quotient, hold_q);
            check_eq("hold_remainder", remainder, hold_r);
            @(negedge clk);
            lat++;
        end
        exp_q = (b == 0) ? MAXV : a / b;
        exp_r = (b == 0) ? a : a % b;
        exp_z = (b == 0) ? 1 : 0;
        check_eq("done_seen", done, 1);
        check_eq("latency", lat, (b == 0) ? 1 : WIDTH + 1);
        check_eq("busy_cycles", nbusy, (b == 0) ? 0 : WIDTH);
        check_eq("busy_at_done", busy, 0);
        check_eq("quotient", quotient, exp_q);
        check_eq("remainder", remainder, exp_r);
        check_eq("div_by_zero", div_by_zero, exp_z);
        if (b != 0) begin
            dq = int'(quotient);
            dr = int'(remainder);
            check_eq("invariant", dq * b + dr, a);
            check_eq("rem_lt_divisor", (dr < b) ? 1 : 0, 1);
        end
        hold_q = exp_q;
        hold_r = exp_r;
    endtask

    task automatic run_div(input int a, input int b);
        start_op(a, b);
        await_result(a, b);
        @(negedge clk);
        check_eq("done_single_pulse", done, 0);
    endtask

    initial begin
        int dones;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_quotient", quotient, 0);
        check_eq("rst_remainder", remainder, 0);
        check_eq("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_div(13, 3);
        run_div(15, 1);
        run_div(2, 7);
        run_div(15, 15);

        run_div(9, 0);
        run_div(8, 2);

        // Second request during CALC must be ignored.
        start_op(13, 3);
        dones = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) begin
                start    = 1'b1;
                dividend = 4'd6;
                divisor  = 4'd2;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                check_eq("ignore_quotient", quotient, 4);
                check_eq("ignore_remainder", remainder, 1);
            end
            @(negedge clk);
        end
        check_eq("ignore_done_count", dones, 1);
        hold_q = 4;
        hold_r = 1;

        // Reset in the third CALC cycle aborts without a done.
        start_op(14, 4);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_quotient", quotient, 0);
        check_eq("abort_remainder", remainder, 0);
        check_eq("abort_dbz", div_by_zero, 0);
        rst_n  = 1'b1;
        hold_q = 0;
        hold_r = 0;
        dones  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check_eq("abort_no_done", dones, 0);
        run_div(14, 4);

        // Back-to-back: new request accepted during the done cycle.
        start_op(7, 2);
        await_result(7, 2);
        start_op(11, 5);
        check_eq("b2b_busy", busy, 1);
        await_result(11, 5);
        @(negedge clk);
        check_eq("b2b_done_pulse", done, 0);

        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 1; b <= MAXV; b++) begin
                run_div(a, b);
            end
        end

        for (int i = 0; i < 60; i++) begin
            int a;
            int b;
            a = int'($urandom_range(0, MAXV));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, MAXV));
            if ($urandom_range(0, 3) == 0) begin
                start_op(a, b);
                await_result(a, b);
            end else begin
                run_div(a, b);
            end
        end
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
